// File: rtl/mux21_arbiter.sv
// Round-robin arbiter for the shared 2:1 word mux, with a hold limit and a one-entry output register (1-cycle accept-to-out_valid).
// Readies drop while the output register is full and not draining; MUX21_ARB_STATS_EN adds saturating accept counters on stat0/stat1.
module mux21_arbiter #(
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             select,
    output logic             grant_id,
    output logic [15:0]      stat0,
    output logic [15:0]      stat1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             select_q, select_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic can_load;
    logic accept0;
    logic accept1;
    logic hold_done;

    assign can_load  = !out_valid_q || out_ready;
    assign accept0   = req0_valid && req0_ready;
    assign accept1   = req1_valid && req1_ready;
    assign hold_done = (count_q == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b1;
            select_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            select_q     <= select_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (accept0) begin
                    if (hold_done) begin
                        count_d = 4'd0;
                        state_d = req1_valid ? GRANT1 : IDLE;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end else if (!req0_valid) begin
                    count_d = 4'd0;
                    state_d = req1_valid ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (accept1) begin
                    if (hold_done) begin
                        count_d = 4'd0;
                        state_d = req0_valid ? GRANT0 : IDLE;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end else if (!req1_valid) begin
                    count_d = 4'd0;
                    state_d = req0_valid ? GRANT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // Grant bookkeeping follows the state being entered; select keeps its value through IDLE.
    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        select_d     = select_q;
        if (state_d == GRANT0) begin
            last_grant_d = 1'b0;
            grant_id_d   = 1'b0;
            select_d     = 1'b1;
        end else if (state_d == GRANT1) begin
            last_grant_d = 1'b1;
            grant_id_d   = 1'b1;
            select_d     = 1'b0;
        end
    end

    always_comb begin
        req0_ready = (state_q == GRANT0) && can_load;
        req1_ready = (state_q == GRANT1) && can_load;
        select     = select_q;
        grant_id   = grant_id_q;
        out_valid  = out_valid_q;
        out_data   = out_data_q;
    end

    // A same-cycle accept refills the stage while it drains, so back-to-back beats need no gap.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept0) begin
            out_valid_d = 1'b1;
            out_data_d  = req0_data;
        end else if (accept1) begin
            out_valid_d = 1'b1;
            out_data_d  = req1_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef MUX21_ARB_STATS_EN
    logic [15:0] stat0_q;
    logic [15:0] stat1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat0_q <= 16'd0;
            stat1_q <= 16'd0;
        end else begin
            if (accept0 && (stat0_q != 16'hFFFF)) begin
                stat0_q <= stat0_q + 16'd1;
            end
            if (accept1 && (stat1_q != 16'hFFFF)) begin
                stat1_q <= stat1_q + 16'd1;
            end
        end
    end

    assign stat0 = stat0_q;
    assign stat1 = stat1_q;
`else
    assign stat0 = 16'd0;
    assign stat1 = 16'd0;
`endif

endmodule

// File: tb/tb_mux21_arbiter.sv
// Scoreboarded bench for mux21_arbiter: directed reset, round-robin, single, backpressure and async-reset vectors.
module tb_mux21_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        select;
    logic        grant_id;
    logic [15:0] stat0;
    logic [15:0] stat1;

    always #5 clk = ~clk;

    mux21_arbiter #(.WIDTH(32), .HOLD_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .select     (select),
        .grant_id   (grant_id),
        .stat0      (stat0),
        .stat1      (stat1)
    );

`ifdef MUX21_ARB_STATS_EN
    localparam logic [31:0] STAT_RR = 32'd12;
`else
    localparam logic [31:0] STAT_RR = 32'd0;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every consumed output beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: actual=%0h required=none", out_data);
            end else begin
                check("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic a0, a1, got;
        int   n, span, guard, k, blk, seen, iters;

        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 32'd0; req1_data = 32'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_select", 32'(select), 32'd1);
            check("idle_grant_id", 32'(grant_id), 32'd1);
            check("idle_ready0", 32'(req0_ready), 32'd0);
            check("idle_ready1", 32'(req1_ready), 32'd0);
        end
        check("idle_stat0", 32'(stat0), 32'd0);
        check("idle_stat1", 32'(stat1), 32'd0);

        // Round robin: 24 beats, bursts of 4, requester 0 first
        @(posedge clk); #1;
        req0_data = 32'd100; req1_data = 32'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 24; i++) exp_q.push_back(((i / 4) % 2 == 0) ? 32'd100 : 32'd2);
        n = 0; span = 0; guard = 0;
        while (n < 24 && guard < 100) begin
            @(negedge clk);
            guard++;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (n > 0 || a0 || a1) span++;
            if (a0 || a1) begin
                check("rr_select", 32'(select), ((n / 4) % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_winner0", 32'(a0), ((n / 4) % 2 == 0) ? 32'd1 : 32'd0);
                n++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_beats", 32'(n), 32'd24);
        check("rr_span_no_bubble", 32'(span), 32'd24);
        wait_drain("rr_drain");
        check("rr_stat0", 32'(stat0), STAT_RR);
        check("rr_stat1", 32'(stat1), STAT_RR);

        // Single requester 0, one word
        @(posedge clk); #1;
        req0_data = 32'd100; req0_valid = 1'b1;
        exp_q.push_back(32'd100);
        @(negedge clk);
        check("single_bubble_ready0", 32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_ready0", 32'(req0_ready), 32'd1);
        check("single_select", 32'(select), 32'd1);
        check("single_grant_id", 32'(grant_id), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", out_data, 32'd100);
        wait_drain("single_drain");
        @(posedge clk); #1;
        @(negedge clk);
        check("single_idle_out_valid", 32'(out_valid), 32'd0);
        check("single_idle_ready0", 32'(req0_ready), 32'd0);
        check("single_idle_select", 32'(select), 32'd1);

        // Backpressure: 6 words, out_ready low 3 cycles after first word, garbage data while blocked
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h200 + 32'(i));
        req0_data = 32'h200; req0_valid = 1'b1;
        k = 0; blk = 0; seen = 0; iters = 0;
        while (k < 6 && iters < 100) begin
            @(negedge clk);
            iters++;
            a0 = req0_valid && req0_ready;
            if (!out_ready) begin
                check("bp_ready0_low", 32'(req0_ready), 32'd0);
                check("bp_out_valid_held", 32'(out_valid), 32'd1);
                check("bp_out_data_held", out_data, 32'h200);
            end
            @(posedge clk); #1;
            if (a0) k++;
            if (seen == 0 && out_valid) begin
                seen = 1;
                blk  = 3;
            end
            if (blk > 0) begin
                out_ready = 1'b0;
                req0_data = 32'hBAD0BAD0;
                blk--;
            end else begin
                out_ready = 1'b1;
                req0_data = 32'h200 + 32'(k);
            end
            if (k == 6) req0_valid = 1'b0;
        end
        out_ready = 1'b1;
        req0_valid = 1'b0;
        check("bp_cycles", 32'(iters), 32'd11);
        wait_drain("bp_drain");

        // Reset with a word held in the output register
        @(posedge clk); #1;
        req0_data = 32'h400; req0_valid = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_select", 32'(select), 32'd1);
        check("rst_grant_id", 32'(grant_id), 32'd1);
        check("rst_stat0", 32'(stat0), 32'd0);
        req0_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        req0_data = 32'h300; req1_data = 32'h301;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_q.push_back(32'h300);
        got = 1'b0; guard = 0;
        while (!got && guard < 20) begin
            @(negedge clk);
            guard++;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 || a1) begin
                got = 1'b1;
                check("rst_first_winner0", 32'(a0), 32'd1);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rst_got_beat", 32'(got), 32'd1);
        wait_drain("rst_drain");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
